rv_issue_arb: RTL and testbench
===============================

Name: rv_issue_arb

Overview:
Reservation-station issue arbiter. Holds per-entry valid/ready state and builds the request vector (valid & ready & not-presented). Picks one entry through the find-first picker, registers the grant and presents it downstream with a valid/take handshake. Sits between the RV entry allocator/wakeup logic and the issue read-out mux; the entry is freed when the grant is taken.

Parameters:
ENTRIES, 16, number of RV entries (2..32).
IDX_W, 4, index width, equal to clog2(ENTRIES).

Ports:
clk  in  1  clock.
rst  in  1  reset; synchronous, active-high.
flush  in  1  clears all entries and the presented grant.
alloc_vld  in  1  allocate entry alloc_idx.
alloc_idx  in  IDX_W  entry being allocated.
alloc_rdy  in  1  entry is ready at allocation.
wake_vec  in  ENTRIES  per-entry set-ready pulses.
issue_vld  out  1  grant presented.
issue_idx  out  IDX_W  binary index of the granted entry.
issue_oh  out  ENTRIES  one-hot form of the grant; bit 0 is highest priority.
issue_take  in  1  downstream consumes the grant this cycle.
free_vec  out  ENTRIES  equal to ~valid; used by the allocator.
count  out  IDX_W+1  number of valid entries.
full  out  1  count == ENTRIES.
empty  out  1  count == 0.

Behaviour:
- Reset: valid, ready, issue_vld, issue_oh, issue_idx and count are all 0. free_vec is all 1s, empty=1, full=0.
- Per-entry state: valid and ready flops.
- Alloc at edge N: valid=1 and ready=alloc_rdy. Alloc to an entry that is already valid is illegal; the bench asserts on it.
- Wake: ready |= wake_vec for valid entries. Wake to an invalid entry is ignored. Alloc and wake to the same entry in the same cycle gives ready=1.
- Request vector req = valid & ready & ~(issue_oh & {ENTRIES{issue_vld}}). This stops the presented entry being picked twice.
- Picker: find-first on req (lowest index wins), combinational.
- Grant register load condition: load = ~issue_vld | issue_take.
  - When load is true: issue_vld <= |req, issue_oh <= pick, issue_idx <= encode(pick).
  - When load is false (stall): issue_vld, issue_oh and issue_idx hold, even if a higher-priority entry becomes ready.
- Latency:
  - Entry allocated ready at edge N is presented at edge N+1 if the register is loadable.
  - Consecutive grants issue back-to-back, one per cycle, while issue_take=1.
- Take: when issue_vld & issue_take, the entry at issue_idx gets valid=0 and ready=0 on the next edge. issue_take while issue_vld=0 is ignored.
- Simultaneous take of entry k and alloc of entry k: alloc wins, and the entry is valid with the new ready value.
- count is a registered counter:
  - +1 on alloc, -1 on take, unchanged when both occur.
  - It must equal popcount(valid); the bench asserts this.
- Flush has highest priority:
  - Next edge: all valid=0, ready=0, issue_vld=0, count=0.
  - Alloc, wake and take in the same cycle are discarded.
- Reset mid-operation behaves identically to flush and also returns all outputs to their reset values.
- Outputs issue_* come from flops. free_vec, full and empty are decoded from flops.

Optional Feature:
RV_ISSUE_RR_EN:
- Defined:
  - A last-grant pointer (IDX_W flops, reset 0) updates on every take.
  - Priority rotates: a masked req (bits above the last grant) is picked first; if the masked req is empty, unmasked req is picked.
  - This costs a second picker instance.
- Undefined: fixed priority, index 0 highest, and a single picker.

Decomposition:
- Shared package rv_pkg: RV_ENTRIES default, RV_IDX_W, and a one-hot-to-index encode function. The encode function is also used by issue read-out.
- Sub-module: the existing rv_pri find-first picker (size=ENTRIES), instantiated once, or twice under RV_ISSUE_RR_EN.
- No other sub-modules.

Test Plan:
- Reset -> issue_vld=0, count=0, free_vec=16'hFFFF, empty=1, full=0.
- Alloc 7 (rdy=1) at edge 1, alloc 3 (rdy=1) at edge 2, issue_take=1 throughout -> issue_idx=7 after edge 2, issue_idx=3 after edge 3, issue_vld=0 after edge 4; count goes 1,2,1,0.
- Entries 5 and 9 ready, issue_take=0 for 3 cycles, wake entry 1 during the stall -> issue_idx stays 5 until take; then grants go 1, then 9.
- Stall with entries 2,4,6 valid, then flush together with alloc 8 -> next cycle issue_vld=0, count=0, free_vec all 1s, entry 8 not valid.
- Alloc all 16 with rdy=0 -> full=1. Take blocked (nothing ready). Wake entry 15 -> issue_idx=15. Take together with alloc 15 -> full stays 1 and count stays 16.
- RV_ISSUE_RR_EN defined: entries 0 and 1 kept ready and re-allocated after each take -> grants alternate 0,1,0,1. Undefined: grants are always 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the reservation-station issue path.
// Holds the default entry count, the derived index width and a one-hot to
// binary encoder that is shared by the issue arbiter and the issue read-out mux.
package rv_pkg;

  localparam int RV_ENTRIES     = 16;
  localparam int RV_IDX_W       = $clog2(RV_ENTRIES);

  // Upper bound on the supported entry count; the encoder is sized for it so
  // every instance can share one function regardless of its ENTRIES value.
  localparam int RV_MAX_ENTRIES = 32;
  localparam int RV_MAX_IDX_W   = 5;

  // One-hot to binary. OR-ing indices is exact for a one-hot input and
  // returns 0 for an all-zero input, which is the idle grant index.
  function automatic logic [RV_MAX_IDX_W-1:0] rv_oh2idx(
    input logic [RV_MAX_ENTRIES-1:0] oh
  );
    logic [RV_MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < RV_MAX_ENTRIES; i++) begin
      if (oh[i]) idx = idx | RV_MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rv_pri.sv
// Find-first picker: grants the lowest-index set bit of the request vector.
// Purely combinational; o_any flags that at least one request is set.
module rv_pri
  import rv_pkg::*;
#(
  parameter int SIZE = RV_ENTRIES
) (
  input  logic [SIZE-1:0] i_req,
  output logic [SIZE-1:0] o_gnt,
  output logic            o_any
);

  // x & -x isolates the lowest set bit without a priority chain in source.
  assign o_gnt = i_req & (~i_req + SIZE'(1));
  assign o_any = |i_req;

endmodule

// File: rtl/rv_issue_arb.sv
// Reservation-station issue arbiter.
// Tracks per-entry valid/ready, builds the request vector (valid & ready &
// not currently presented), picks one entry and presents it downstream from
// registers with a valid/take handshake. A taken entry is freed.
// Optional build macro RV_ISSUE_RR_EN: rotating priority starting just above
// the last taken entry (second picker instance). Default: fixed priority,
// index 0 highest.
module rv_issue_arb
  import rv_pkg::*;
#(
  parameter int ENTRIES = RV_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_flush,
  input  logic               i_alloc_vld,
  input  logic [IDX_W-1:0]   i_alloc_idx,
  input  logic               i_alloc_rdy,
  input  logic [ENTRIES-1:0] i_wake_vec,
  output logic               o_issue_vld,
  output logic [IDX_W-1:0]   o_issue_idx,
  output logic [ENTRIES-1:0] o_issue_oh,
  input  logic               i_issue_take,
  output logic [ENTRIES-1:0] o_free_vec,
  output logic [IDX_W:0]     o_count,
  output logic               o_full,
  output logic               o_empty
);

  localparam int CNT_W = IDX_W + 1;

  // Entry state and presented grant.
  logic [ENTRIES-1:0] r_valid;
  logic [ENTRIES-1:0] r_ready;
  logic               r_issue_vld;
  logic [ENTRIES-1:0] r_issue_oh;
  logic [IDX_W-1:0]   r_issue_idx;
  logic [CNT_W-1:0]   r_count;

  logic [ENTRIES-1:0] w_req;
  logic [ENTRIES-1:0] w_pick;
  logic               w_any;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_load;
  logic               w_take;
  logic [ENTRIES-1:0] w_take_oh;
  logic [ENTRIES-1:0] w_alloc_oh;
  logic [ENTRIES-1:0] w_valid_nxt;
  logic [ENTRIES-1:0] w_ready_nxt;
  logic [CNT_W-1:0]   w_count_nxt;

  // The presented entry is masked out so it cannot be picked a second time
  // while it waits for take.
  assign w_req = r_valid & r_ready & ~(r_issue_oh & {ENTRIES{r_issue_vld}});

  // The grant register reloads whenever it is empty or being consumed;
  // otherwise it holds even if a higher-priority entry becomes ready.
  assign w_load    = ~r_issue_vld | i_issue_take;
  assign w_take    = r_issue_vld & i_issue_take;
  assign w_take_oh = r_issue_oh & {ENTRIES{w_take}};

`ifdef RV_ISSUE_RR_EN
  logic [IDX_W-1:0]   r_last;
  logic [ENTRIES-1:0] w_mask;
  logic [ENTRIES-1:0] w_req_m;
  logic [ENTRIES-1:0] w_pick_m;
  logic [ENTRIES-1:0] w_pick_u;
  logic               w_any_m;

  // Mask keeps only entries strictly above the last taken one.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_mask[i] = (i > int'(r_last));
    end
  end

  assign w_req_m = w_req & w_mask;

  rv_pri #(.SIZE(ENTRIES)) u_pri_masked (
    .i_req (w_req_m),
    .o_gnt (w_pick_m),
    .o_any (w_any_m)
  );

  rv_pri #(.SIZE(ENTRIES)) u_pri_unmasked (
    .i_req (w_req),
    .o_gnt (w_pick_u),
    .o_any (w_any)
  );

  // Prefer the rotated request; wrap to plain priority when nothing is above.
  assign w_pick = w_any_m ? w_pick_m : w_pick_u;

  // Last-grant pointer follows every take; flush leaves it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= '0;
    end else if (!i_flush && w_take) begin
      r_last <= r_issue_idx;
    end
  end
`else
  rv_pri #(.SIZE(ENTRIES)) u_pri (
    .i_req (w_req),
    .o_gnt (w_pick),
    .o_any (w_any)
  );
`endif

  assign w_pick_idx = IDX_W'(rv_oh2idx(RV_MAX_ENTRIES'(w_pick)));

  // Decode the allocation index into a one-hot update mask.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_alloc_oh = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_alloc_oh[i] = i_alloc_vld && (int'(i_alloc_idx) == i);
    end
  end

  // Next entry state: wake only touches valid entries, take clears the
  // presented entry, and a same-cycle alloc of that entry wins over the take.
  always_comb begin
    w_valid_nxt = (r_valid & ~w_take_oh) | w_alloc_oh;
    w_ready_nxt = ((r_ready | (i_wake_vec & r_valid)) & ~w_take_oh & ~w_alloc_oh)
                | (w_alloc_oh & ({ENTRIES{i_alloc_rdy}} | i_wake_vec));
  end

  // Occupancy counter: alloc and take in the same cycle cancel out.
  always_comb begin
    w_count_nxt = r_count;
    case ({i_alloc_vld, w_take})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Entry state and counter; flush clears everything and drops same-cycle
  // alloc/wake/take.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst || i_flush) begin
      r_valid <= '0;
      r_ready <= '0;
      r_count <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_ready <= w_ready_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Grant register: reloads from the picker when empty or taken, else holds.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_issue_vld <= 1'b0;
      r_issue_oh  <= '0;
      r_issue_idx <= '0;
    end else if (w_load) begin
      r_issue_vld <= w_any;
      r_issue_oh  <= w_pick;
      r_issue_idx <= w_pick_idx;
    end
  end

  assign o_issue_vld = r_issue_vld;
  assign o_issue_idx = r_issue_idx;
  assign o_issue_oh  = r_issue_oh;
  assign o_free_vec  = ~r_valid;
  assign o_count     = r_count;
  assign o_full      = (r_count == CNT_W'(ENTRIES));
  assign o_empty     = (r_count == '0);

endmodule

// File: tb/tb_rv_issue_arb.sv
// Self-checking bench for rv_issue_arb: directed scenarios plus randomized
// traffic checked against a behavioural model built from per-entry arrays.
module tb_rv_issue_arb;

  localparam int N = 16;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         alloc_vld;
  logic [W-1:0] alloc_idx;
  logic         alloc_rdy;
  logic [N-1:0] wake;
  logic         take;
  logic         issue_vld;
  logic [W-1:0] issue_idx;
  logic [N-1:0] issue_oh;
  logic [N-1:0] free_vec;
  logic [W:0]   count;
  logic         full;
  logic         empty;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit m_valid[N];
  bit m_ready[N];
  bit m_vld;
  int m_idx;
  int m_last;

  rv_issue_arb #(.ENTRIES(N), .IDX_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (flush),
    .i_alloc_vld  (alloc_vld),
    .i_alloc_idx  (alloc_idx),
    .i_alloc_rdy  (alloc_rdy),
    .i_wake_vec   (wake),
    .o_issue_vld  (issue_vld),
    .o_issue_idx  (issue_idx),
    .o_issue_oh   (issue_oh),
    .i_issue_take (take),
    .o_free_vec   (free_vec),
    .o_count      (count),
    .o_full       (full),
    .o_empty      (empty)
  );

  always #5 clk = ~clk;

  function automatic bit cand(int i);
    return m_valid[i] && m_ready[i] && !(m_vld && m_idx == i);
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, and return
  // 1 time unit after the edge with outputs settled.
  task automatic step(input bit a_v, input int a_i, input bit a_r,
                      input logic [N-1:0] wk, input bit tk, input bit fl, input bit rs);
    int pick;
    bit taken;
    bit load;
    rst = rs; flush = fl; alloc_vld = a_v; alloc_idx = W'(a_i);
    alloc_rdy = a_r; wake = wk; take = tk;
    if (!rs && !fl && a_v)
      assert (!m_valid[a_i] || (m_vld && tk && m_idx == a_i))
        else $error("illegal alloc to busy entry %0d", a_i);
    @(posedge clk);
    if (rs || fl) begin
      for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_ready[i] = 0; end
      m_vld = 0; m_idx = 0;
      if (rs) m_last = 0;
    end else begin
      pick = -1;
`ifdef RV_ISSUE_RR_EN
      for (int i = m_last + 1; i < N; i++) if (pick < 0 && cand(i)) pick = i;
`endif
      for (int i = 0; i < N; i++) if (pick < 0 && cand(i)) pick = i;
      taken = m_vld && tk;
      load  = !m_vld || tk;
      for (int i = 0; i < N; i++) if (m_valid[i] && wk[i]) m_ready[i] = 1;
      if (taken) begin
        m_valid[m_idx] = 0; m_ready[m_idx] = 0; m_last = m_idx;
      end
      if (a_v) begin m_valid[a_i] = 1; m_ready[a_i] = a_r | wk[a_i]; end
      if (load) begin m_vld = (pick >= 0); m_idx = (pick >= 0) ? pick : 0; end
    end
    #1;
  endtask

  task automatic idle(input bit tk);
    step(0, 0, 0, '0, tk, 0, 0);
  endtask

  task automatic test_reset();
    step(0, 0, 0, '0, 0, 0, 1);
    step(1, 3, 1, 16'hFFFF, 1, 0, 1);
    total++; if (issue_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%0d want=0", issue_vld); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (free_vec !== 16'hFFFF) begin bad++; $display("FAIL reset_free got=%h want=ffff", free_vec); end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags empty=%0d full=%0d want 1/0", empty, full); end
    total++; if (issue_oh !== '0 || issue_idx !== '0) begin bad++; $display("FAIL reset_grant oh=%h idx=%0d want 0/0", issue_oh, issue_idx); end
  endtask

  task automatic test_order();
    step(0, 0, 0, '0, 0, 0, 1);
    step(1, 7, 1, '0, 1, 0, 0);
    total++; if (count !== 5'd1 || issue_vld !== 1'b0) begin bad++; $display("FAIL order_e1 count=%0d vld=%0d want 1/0", count, issue_vld); end
    step(1, 3, 1, '0, 1, 0, 0);
    total++; if (issue_vld !== 1'b1 || issue_idx !== 4'd7 || count !== 5'd2) begin bad++; $display("FAIL order_e2 vld=%0d idx=%0d count=%0d want 1/7/2", issue_vld, issue_idx, count); end
    idle(1);
    total++; if (issue_vld !== 1'b1 || issue_idx !== 4'd3 || count !== 5'd1) begin bad++; $display("FAIL order_e3 vld=%0d idx=%0d count=%0d want 1/3/1", issue_vld, issue_idx, count); end
    idle(1);
    total++; if (issue_vld !== 1'b0 || count !== 5'd0) begin bad++; $display("FAIL order_e4 vld=%0d count=%0d want 0/0", issue_vld, count); end
  endtask

  task automatic test_stall();
    step(0, 0, 0, '0, 0, 0, 1);
    step(1, 1, 0, '0, 0, 0, 0);
    step(1, 5, 1, '0, 0, 0, 0);
    step(1, 9, 1, '0, 0, 0, 0);
    total++; if (issue_vld !== 1'b1 || issue_idx !== 4'd5) begin bad++; $display("FAIL stall_first vld=%0d idx=%0d want 1/5", issue_vld, issue_idx); end
    step(0, 0, 0, 16'h0002, 0, 0, 0);
    idle(0);
    idle(0);
    total++; if (issue_idx !== 4'd5 || issue_oh !== 16'h0020) begin bad++; $display("FAIL stall_hold idx=%0d oh=%h want 5/0020", issue_idx, issue_oh); end
    idle(1);
    total++; if (issue_vld !== 1'b1 || issue_idx !== 4'd1) begin bad++; $display("FAIL stall_next1 vld=%0d idx=%0d want 1/1", issue_vld, issue_idx); end
    idle(1);
    total++; if (issue_vld !== 1'b1 || issue_idx !== 4'd9) begin bad++; $display("FAIL stall_next9 vld=%0d idx=%0d want 1/9", issue_vld, issue_idx); end
    idle(1);
    total++; if (issue_vld !== 1'b0 || count !== 5'd0) begin bad++; $display("FAIL stall_drain vld=%0d count=%0d want 0/0", issue_vld, count); end
  endtask

  task automatic test_flush();
    step(0, 0, 0, '0, 0, 0, 1);
    step(1, 2, 1, '0, 0, 0, 0);
    step(1, 4, 1, '0, 0, 0, 0);
    step(1, 6, 1, '0, 0, 0, 0);
    idle(0);
    total++; if (issue_vld !== 1'b1 || issue_idx !== 4'd2 || count !== 5'd3) begin bad++; $display("FAIL flush_pre vld=%0d idx=%0d count=%0d want 1/2/3", issue_vld, issue_idx, count); end
    step(1, 8, 1, 16'hFFFF, 1, 1, 0);
    total++; if (issue_vld !== 1'b0 || count !== 5'd0 || free_vec !== 16'hFFFF || empty !== 1'b1) begin bad++; $display("FAIL flush_clear vld=%0d count=%0d free=%h empty=%0d want 0/0/ffff/1", issue_vld, count, free_vec, empty); end
    idle(0);
    total++; if (issue_vld !== 1'b0 || free_vec !== 16'hFFFF) begin bad++; $display("FAIL flush_alloc_dropped vld=%0d free=%h want 0/ffff", issue_vld, free_vec); end
  endtask

  task automatic test_full();
    step(0, 0, 0, '0, 0, 0, 1);
    for (int i = 0; i < N; i++) step(1, i, 0, '0, 1, 0, 0);
    total++; if (full !== 1'b1 || count !== 5'd16 || free_vec !== 16'h0000 || empty !== 1'b0) begin bad++; $display("FAIL full_set full=%0d count=%0d free=%h want 1/16/0000", full, count, free_vec); end
    idle(1);
    total++; if (issue_vld !== 1'b0) begin bad++; $display("FAIL full_none_ready vld=%0d want 0", issue_vld); end
    step(0, 0, 0, 16'h8000, 0, 0, 0);
    idle(0);
    total++; if (issue_vld !== 1'b1 || issue_idx !== 4'd15 || issue_oh !== 16'h8000) begin bad++; $display("FAIL full_wake15 vld=%0d idx=%0d oh=%h want 1/15/8000", issue_vld, issue_idx, issue_oh); end
    step(1, 15, 0, '0, 1, 0, 0);
    total++; if (full !== 1'b1 || count !== 5'd16 || issue_vld !== 1'b0) begin bad++; $display("FAIL full_take_alloc full=%0d count=%0d vld=%0d want 1/16/0", full, count, issue_vld); end
  endtask

  task automatic test_rr();
    int exp_first;
    step(0, 0, 0, '0, 0, 0, 1);
    for (int r = 0; r < 4; r++) begin
`ifdef RV_ISSUE_RR_EN
      exp_first = (r % 2 == 0) ? 1 : 0;
`else
      exp_first = 0;
`endif
      step(1, 0, 0, '0, 0, 0, 0);
      step(1, 1, 0, '0, 0, 0, 0);
      step(0, 0, 0, 16'h0003, 0, 0, 0);
      idle(0);
      total++; if (issue_vld !== 1'b1 || int'(issue_idx) != exp_first) begin bad++; $display("FAIL rr_round%0d vld=%0d idx=%0d want 1/%0d", r, issue_vld, issue_idx, exp_first); end
      idle(1);
      total++; if (int'(issue_idx) != 1 - exp_first) begin bad++; $display("FAIL rr_other%0d idx=%0d want %0d", r, issue_idx, 1 - exp_first); end
      step(0, 0, 0, '0, 0, 1, 0);
    end
  endtask

  task automatic test_random();
    bit a_v, a_r, tk, fl, rs;
    int a_i;
    logic [N-1:0] wk, e_free, e_oh;
    int e_cnt;
    step(0, 0, 0, '0, 0, 0, 1);
    for (int c = 0; c < 800; c++) begin
      a_v = ($urandom % 3) != 0;
      a_i = $urandom % N;
      a_r = $urandom % 2;
      wk  = N'($urandom & $urandom & $urandom);
      tk  = ($urandom % 4) != 0;
      fl  = ($urandom % 60) == 0;
      rs  = ($urandom % 250) == 0;
      if (a_v && m_valid[a_i] && !(m_vld && tk && m_idx == a_i)) a_v = 0;
      step(a_v, a_i, a_r, wk, tk, fl, rs);
      e_cnt = 0;
      for (int i = 0; i < N; i++) begin e_free[i] = !m_valid[i]; e_cnt += int'(m_valid[i]); end
      e_oh = m_vld ? (N'(1) << m_idx) : '0;
      total++; if (issue_vld !== m_vld) begin bad++; $display("FAIL rnd_vld c=%0d got=%0d want=%0d", c, issue_vld, m_vld); end
      total++; if (int'(issue_idx) != m_idx) begin bad++; $display("FAIL rnd_idx c=%0d got=%0d want=%0d", c, issue_idx, m_idx); end
      total++; if (issue_oh !== e_oh) begin bad++; $display("FAIL rnd_oh c=%0d got=%h want=%h", c, issue_oh, e_oh); end
      total++; if (free_vec !== e_free) begin bad++; $display("FAIL rnd_free c=%0d got=%h want=%h", c, free_vec, e_free); end
      total++; if (int'(count) != e_cnt) begin bad++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, count, e_cnt); end
      total++; if (full !== (e_cnt == N) || empty !== (e_cnt == 0)) begin bad++; $display("FAIL rnd_flags c=%0d full=%0d empty=%0d cnt=%0d", c, full, empty, e_cnt); end
      total++; if (int'(count) != $countones(~free_vec)) begin bad++; $display("FAIL rnd_popcount c=%0d count=%0d valid_bits=%0d", c, count, $countones(~free_vec)); end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; alloc_vld = 1'b0; alloc_idx = '0;
    alloc_rdy = 1'b0; wake = '0; take = 1'b0;
    test_reset();
    test_order();
    test_stall();
    test_flush();
    test_full();
    test_rr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
